// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared definitions for the score sequencer: note mode codes, score-word field
// positions, the sequencer state encoding and small word-decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package score_pkg;

  // Note articulation codes; BPM_COMM in the top two bits marks a command word.
  localparam logic [1:0] MODE_NORMAL   = 2'b00;
  localparam logic [1:0] MODE_STACCATO = 2'b01;
  localparam logic [1:0] MODE_SLURRED  = 2'b10;
  localparam logic [1:0] MODE_BPM_COMM = 2'b11;

  // Score word field positions.
  localparam int MODE_MSB = 15;
  localparam int MODE_LSB = 14;
  localparam int TONE_MSB = 13;
  localparam int TONE_LSB = 8;
  localparam int LEN_MSB  = 3;
  localparam int LEN_LSB  = 0;
  localparam int BPM_MSB  = 7;
  localparam int BPM_LSB  = 0;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_NOTE   = 2'd3
  } state_e;

  // What a fetched score word asks the sequencer to do.
  typedef enum logic [1:0] {
    WORD_NOTE  = 2'd0,
    WORD_TEMPO = 2'd1,
    WORD_END   = 2'd2
  } word_kind_e;

  // Classify a score word: command words carry a zero low byte for end-of-song.
  function automatic word_kind_e word_kind(input logic [15:0] w);
    word_kind_e k;
    if (w[MODE_MSB:MODE_LSB] != MODE_BPM_COMM) begin
      k = WORD_NOTE;
    end else if (w[BPM_MSB:BPM_LSB] == 8'h00) begin
      k = WORD_END;
    end else begin
      k = WORD_TEMPO;
    end
    return k;
  endfunction

  // Articulation of a note word; the command code can never reach a note.
  function automatic logic [1:0] note_mode_of(input logic [15:0] w);
    logic [1:0] m;
    case (w[MODE_MSB:MODE_LSB])
      MODE_NORMAL:   m = MODE_NORMAL;
      MODE_STACCATO: m = MODE_STACCATO;
      MODE_SLURRED:  m = MODE_SLURRED;
      default:       m = MODE_NORMAL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/score_sequencer_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// One-register rising-edge detector for an already debounced level.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   din   in  level input
//   rise  out high for the cycle in which din is 1 and was 0 one cycle earlier
// The output is combinational from din so that a rise acts in the same cycle.
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next value of the delayed copy of the input.
  always_comb begin
    prev_d = din;
  end

  // Delayed copy of the input level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/score_sequencer.sv
// -----------------------------------------------------------------------------
// score_sequencer
// Playback scheduler between the score memory and the note timing/tone
// datapath. Fetches one score word per request/acknowledge handshake, decodes
// it into a note, a tempo command or end-of-song, hands notes to the timing
// controller and waits for their completion. Owns play/pause, file tempo and
// restart-to-start-of-song.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   play_btn     debounced level; each rising edge toggles play/pause
//   stop         synchronous level: rewind, reload tempo, halt, clear err
//   mem_req      out pulse requesting the next score word
//   mem_ack      in pulse, mem_data valid in the same cycle
//   mem_data     16-bit score word
//   mem_rewind   out pulse resetting the memory address to word 0
//   note_start   out pulse; note_tone/len/mode valid from this cycle, held
//   note_tone    tone index (word[13:8])
//   note_len     duration code (word[3:0])
//   note_mode    articulation (word[15:14])
//   note_en      high while a note sounds and playback is not paused
//   note_done    in pulse from the timing controller
//   default_bpm  tempo from the latest tempo command
//   playing      play state
//   song_end     out pulse on end-of-song
//   err          sticky fetch-timeout flag
// All outputs are registered.
// -----------------------------------------------------------------------------
module score_sequencer #(
  parameter logic [7:0] DEFAULT_BPM = 8'd80,
  parameter logic [9:0] ACK_TIMEOUT = 10'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_btn,
  input  logic        stop,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        mem_rewind,
  output logic        note_start,
  output logic [5:0]  note_tone,
  output logic [3:0]  note_len,
  output logic [1:0]  note_mode,
  output logic        note_en,
  input  logic        note_done,
  output logic [7:0]  default_bpm,
  output logic        playing,
  output logic        song_end,
  output logic        err
);

  import score_pkg::*;

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [9:0]  cnt_q, cnt_d;
  // A request has been issued and its acknowledge is still outstanding.
  logic        wait_q, wait_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_rewind_q, mem_rewind_d;
  logic        note_start_q, note_start_d;
  logic [5:0]  tone_q, tone_d;
  logic [3:0]  len_q, len_d;
  logic [1:0]  mode_q, mode_d;
  logic        note_en_q, note_en_d;
  logic [7:0]  bpm_q, bpm_d;
  logic        playing_q, playing_d;
  logic        song_end_q, song_end_d;
  logic        err_q, err_d;

  logic        rise_s;
  logic        toggled_s;
  logic        timeout_s;
  word_kind_e  kind_s;

  rise_detect u_play_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (play_btn),
    .rise (rise_s)
  );

  // Next-state and output decode; priority stop > timeout > pause toggle > normal.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    playing_d    = playing_q;
    err_d        = err_q;
    bpm_d        = bpm_q;
    tone_d       = tone_q;
    len_d        = len_q;
    mode_d       = mode_q;
    mem_req_d    = 1'b0;
    mem_rewind_d = 1'b0;
    note_start_d = 1'b0;
    song_end_d   = 1'b0;
    toggled_s    = rise_s ? ~playing_q : playing_q;
    // An ack in the last allowed cycle still wins over the timeout.
    timeout_s    = (state_q == ST_FETCH) && wait_q && !mem_ack && (cnt_q >= ACK_TIMEOUT);
    kind_s       = word_kind(word_q);

    if (stop) begin
      state_d      = ST_IDLE;
      wait_d       = 1'b0;
      cnt_d        = 10'd0;
      playing_d    = 1'b0;
      err_d        = 1'b0;
      bpm_d        = DEFAULT_BPM;
      tone_d       = 6'd0;
      len_d        = 4'd0;
      mode_d       = 2'd0;
      mem_rewind_d = 1'b1;
    end else if (timeout_s) begin
      state_d   = ST_IDLE;
      wait_d    = 1'b0;
      cnt_d     = 10'd0;
      playing_d = 1'b0;
      err_d     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_s) begin
            playing_d = 1'b1;
            state_d   = ST_FETCH;
            mem_req_d = 1'b1;
            wait_d    = 1'b1;
            cnt_d     = 10'd0;
          end else begin
            playing_d = 1'b0;
          end
        end

        ST_FETCH: begin
          playing_d = toggled_s;
          if (wait_q) begin
            // The handshake completes even while paused.
            if (mem_ack) begin
              word_d  = mem_data;
              wait_d  = 1'b0;
              cnt_d   = 10'd0;
              state_d = ST_DECODE;
            end else begin
              cnt_d = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;
            end
          end else if (toggled_s) begin
            // Entered FETCH while paused: the request goes out on resume.
            mem_req_d = 1'b1;
            wait_d    = 1'b1;
            cnt_d     = 10'd0;
          end else begin
            cnt_d = 10'd0;
          end
        end

        ST_DECODE: begin
          if (rise_s) begin
            // A toggle holds the decode for at least one more cycle.
            playing_d = toggled_s;
          end else if (playing_q) begin
            case (kind_s)
              WORD_END: begin
                song_end_d   = 1'b1;
                mem_rewind_d = 1'b1;
                bpm_d        = DEFAULT_BPM;
                playing_d    = 1'b0;
                state_d      = ST_IDLE;
              end
              WORD_TEMPO: begin
                bpm_d     = word_q[BPM_MSB:BPM_LSB];
                state_d   = ST_FETCH;
                mem_req_d = 1'b1;
                wait_d    = 1'b1;
                cnt_d     = 10'd0;
              end
              default: begin
                tone_d       = word_q[TONE_MSB:TONE_LSB];
                len_d        = word_q[LEN_MSB:LEN_LSB];
                mode_d       = note_mode_of(word_q);
                note_start_d = 1'b1;
                state_d      = ST_NOTE;
              end
            endcase
          end else begin
            state_d = ST_DECODE;
          end
        end

        ST_NOTE: begin
          playing_d = toggled_s;
          if (note_done) begin
            // The note is complete; request the next word only if still playing.
            state_d = ST_FETCH;
            if (toggled_s) begin
              mem_req_d = 1'b1;
              wait_d    = 1'b1;
              cnt_d     = 10'd0;
            end else begin
              wait_d = 1'b0;
              cnt_d  = 10'd0;
            end
          end else begin
            state_d = ST_NOTE;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          playing_d = 1'b0;
          wait_d    = 1'b0;
        end
      endcase
    end

    note_en_d = (state_d == ST_NOTE) && playing_d;
  end

  // State, captured word, timeout counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_q       <= 16'h0000;
      cnt_q        <= 10'd0;
      wait_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_rewind_q <= 1'b0;
      note_start_q <= 1'b0;
      tone_q       <= 6'd0;
      len_q        <= 4'd0;
      mode_q       <= 2'd0;
      note_en_q    <= 1'b0;
      bpm_q        <= DEFAULT_BPM;
      playing_q    <= 1'b0;
      song_end_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      mem_req_q    <= mem_req_d;
      mem_rewind_q <= mem_rewind_d;
      note_start_q <= note_start_d;
      tone_q       <= tone_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      note_en_q    <= note_en_d;
      bpm_q        <= bpm_d;
      playing_q    <= playing_d;
      song_end_q   <= song_end_d;
      err_q        <= err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_rewind  = mem_rewind_q;
  assign note_start  = note_start_q;
  assign note_tone   = tone_q;
  assign note_len    = len_q;
  assign note_mode   = mode_q;
  assign note_en     = note_en_q;
  assign default_bpm = bpm_q;
  assign playing     = playing_q;
  assign song_end    = song_end_q;
  assign err         = err_q;

endmodule

// File: tb/tb_score_sequencer.sv
// -----------------------------------------------------------------------------
// tb_score_sequencer
// Scoreboard bench: stimulus pushes the expected observable event (request,
// note start, song end, error) with its cycle into a queue; a monitor process
// pops and compares whenever the DUT presents one of those events.
// -----------------------------------------------------------------------------
module tb_score_sequencer;

  localparam int DEF_BPM = 80;
  localparam int ACK_TO  = 1023;
  localparam int K_REQ   = 0;
  localparam int K_NOTE  = 1;
  localparam int K_END   = 2;
  localparam int K_ERR   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play_btn = 1'b0;
  logic        stop = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic        note_done = 1'b0;
  logic        mem_req, mem_rewind, note_start, note_en, playing, song_end, err;
  logic [5:0]  note_tone;
  logic [3:0]  note_len;
  logic [1:0]  note_mode;
  logic [7:0]  default_bpm;

  typedef struct {
    int kind;
    int cyc;
    int tone;
    int len;
    int mode;
    int bpm;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] song_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  int          model_bpm = DEF_BPM;

  score_sequencer #(
    .DEFAULT_BPM (8'd80),
    .ACK_TIMEOUT (10'd1023)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .play_btn    (play_btn),
    .stop        (stop),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .mem_rewind  (mem_rewind),
    .note_start  (note_start),
    .note_tone   (note_tone),
    .note_len    (note_len),
    .note_mode   (note_mode),
    .note_en     (note_en),
    .note_done   (note_done),
    .default_bpm (default_bpm),
    .playing     (playing),
    .song_end    (song_end),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic string kname(input int k);
    string s;
    case (k)
      K_REQ:   s = "mem_req";
      K_NOTE:  s = "note_start";
      K_END:   s = "song_end";
      default: s = "err";
    endcase
    return s;
  endfunction

  task automatic push(input int kind, input int at, input logic [15:0] w);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    e.tone = int'(w[13:8]);
    e.len  = int'(w[3:0]);
    e.mode = int'(w[15:14]);
    e.bpm  = model_bpm;
    sb_q.push_back(e);
  endtask

  // Reference decode of a score word into the event it must produce.
  task automatic expect_word(input logic [15:0] w, input int at);
    if (w[15:14] == 2'b11) begin
      if (w[7:0] == 8'h00) begin
        model_bpm = DEF_BPM;
        push(K_END, at, w);
      end else begin
        model_bpm = int'(w[7:0]);
        push(K_REQ, at, w);
      end
    end else begin
      push(K_NOTE, at, w);
    end
  endtask

  task automatic check_evt(input int kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected_%s: event at cycle %0d, required none", kname(kind), cyc);
    end else begin
      e = sb_q.pop_front();
      chk({"kind_", kname(kind)}, kind, e.kind);
      chk({"cycle_", kname(kind)}, cyc, e.cyc);
      chk({"bpm_", kname(kind)}, int'(default_bpm), e.bpm);
      case (kind)
        K_NOTE: begin
          chk("note_tone", int'(note_tone), e.tone);
          chk("note_len", int'(note_len), e.len);
          chk("note_mode", int'(note_mode), e.mode);
          chk("note_en_at_start", int'(note_en), 1);
        end
        K_END: begin
          chk("end_rewind", int'(mem_rewind), 1);
          chk("end_playing", int'(playing), 0);
        end
        K_REQ: begin
          chk("req_playing", int'(playing), 1);
        end
        default: begin
          chk("err_playing", int'(playing), 0);
        end
      endcase
    end
  endtask

  // Monitor: compares every observable event against the scoreboard.
  initial begin : monitor
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) check_evt(K_REQ);
      if (note_start) check_evt(K_NOTE);
      if (song_end) check_evt(K_END);
      if (err && !err_prev) check_evt(K_ERR);
      err_prev = err;
    end
  end

  function automatic logic sig_val(input int which);
    logic v;
    case (which)
      0:       v = mem_req;
      1:       v = note_start;
      2:       v = song_end;
      default: v = err;
    endcase
    return v;
  endfunction

  task automatic wait_sig(input int which, input int max_cyc, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      if (sig_val(which)) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) begin
      checks++;
      fails++;
      $display("FAIL timeout_%s: not seen within %0d cycles, required high", name, max_cyc);
    end
  endtask

  task automatic pulse_play(input bit exp_req);
    play_btn = 1'b1;
    if (exp_req) push(K_REQ, cyc + 1, 16'h0000);
    @(negedge clk);
    play_btn = 1'b0;
  endtask

  task automatic pulse_done(input bit exp_req);
    note_done = 1'b1;
    if (exp_req) push(K_REQ, cyc + 1, 16'h0000);
    @(negedge clk);
    note_done = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    model_bpm = DEF_BPM;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit exp_evt);
    mem_ack  = 1'b1;
    mem_data = w;
    if (exp_evt) expect_word(w, cyc + 2);
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_data = 16'($urandom);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(0, 9) < 7) begin
      w[15:14] = 2'($urandom_range(0, 2));
    end else begin
      w[15:14] = 2'b11;
      w[7:0]   = 8'($urandom_range(1, 255));
    end
    return w;
  endfunction

  // Plays song_q from IDLE to its end word, with random ack delays and pauses.
  task automatic run_song();
    pulse_play(1'b1);
    for (int i = 0; i < song_q.size(); i++) begin
      wait_sig(0, 20, "mem_req");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_word(song_q[i], 1'b1);
      if (song_q[i][15:14] != 2'b11) begin
        wait_sig(1, 10, "note_start");
        repeat ($urandom_range(1, 5)) @(negedge clk);
        if ($urandom_range(0, 2) == 0) begin
          pulse_play(1'b0);
          chk("pause_playing", int'(playing), 0);
          chk("pause_note_en", int'(note_en), 0);
          repeat ($urandom_range(1, 4)) @(negedge clk);
          pulse_play(1'b0);
          chk("resume_playing", int'(playing), 1);
          chk("resume_note_en", int'(note_en), 1);
        end
        pulse_done(1'b1);
        chk("done_note_en", int'(note_en), 0);
      end else if (song_q[i][7:0] == 8'h00) begin
        wait_sig(2, 10, "song_end");
        @(negedge clk);
      end
    end
  endtask

  initial begin : stim
    int seen;
    int t_err;
    logic [15:0] w;

    repeat (3) @(negedge clk);
    chk("rst_bpm_held", int'(default_bpm), DEF_BPM);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", int'({mem_req, mem_rewind, note_start, note_tone, note_len,
                                note_mode, note_en, playing, song_end, err}), 0);
    chk("reset_bpm", int'(default_bpm), DEF_BPM);

    // Note, tempo and end words from the score.
    song_q = '{16'h0A15, 16'hC064, 16'hC000};
    run_song();
    chk("after_end_bpm", int'(default_bpm), DEF_BPM);
    chk("after_end_playing", int'(playing), 0);

    // Pause mid-note; note_done arrives while paused.
    @(negedge clk);
    pulse_play(1'b1);
    wait_sig(0, 20, "mem_req");
    send_word(16'h4C2B, 1'b1);
    wait_sig(1, 10, "note_start");
    @(negedge clk);
    pulse_play(1'b0);
    chk("pause2_playing", int'(playing), 0);
    chk("pause2_note_en", int'(note_en), 0);
    pulse_done(1'b0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req) seen++;
    end
    chk("paused_no_req", seen, 0);
    pulse_play(1'b1);
    chk("resume_req", int'(mem_req), 1);
    send_word(16'hC000, 1'b1);
    wait_sig(2, 10, "song_end");
    @(negedge clk);

    // Fetch timeout, then stop clears err.
    t_err = cyc + 1 + ACK_TO + 1;
    pulse_play(1'b1);
    sb_q.push_back('{K_ERR, t_err, 0, 0, 0, DEF_BPM});
    wait_sig(3, ACK_TO + 80, "err");
    chk("timeout_err", int'(err), 1);
    chk("timeout_playing", int'(playing), 0);
    repeat (3) @(negedge clk);
    pulse_stop();
    chk("stop_clears_err", int'(err), 0);
    chk("stop_rewind_after_err", int'(mem_rewind), 1);

    // Stop during FETCH after a tempo change; a late ack is ignored.
    @(negedge clk);
    pulse_play(1'b1);
    wait_sig(0, 20, "mem_req");
    send_word(16'hC0C8, 1'b1);
    wait_sig(0, 20, "mem_req");
    repeat (2) @(negedge clk);
    pulse_stop();
    chk("stop_rewind", int'(mem_rewind), 1);
    chk("stop_playing", int'(playing), 0);
    chk("stop_bpm", int'(default_bpm), DEF_BPM);
    @(negedge clk);
    chk("stop_rewind_one_cycle", int'(mem_rewind), 0);
    send_word(16'h0A15, 1'b0);
    repeat (5) @(negedge clk);
    chk("late_ack_playing", int'(playing), 0);
    chk("late_ack_note_en", int'(note_en), 0);

    // Asynchronous reset in the middle of a note.
    pulse_play(1'b1);
    wait_sig(0, 20, "mem_req");
    send_word(16'h8A37, 1'b1);
    wait_sig(1, 10, "note_start");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", int'({mem_req, mem_rewind, note_start, note_tone, note_len,
                                  note_mode, note_en, playing, song_end, err}), 0);
    chk("rst_mid_bpm", int'(default_bpm), DEF_BPM);
    model_bpm = DEF_BPM;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random songs.
    for (int s = 0; s < 8; s++) begin
      song_q.delete();
      repeat ($urandom_range(3, 8)) song_q.push_back(rand_word());
      w = 16'($urandom);
      w[15:14] = 2'b11;
      w[7:0] = 8'h00;
      song_q.push_back(w);
      run_song();
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
